// File: rtl/bsg_strap_latch_pkg.sv
// bsg_strap_latch_pkg
//   Shared types for the strap latch block.
//   - bsg_strap_latch_state_e : sampling FSM state (eSample while qualifying
//     the strap inputs, eLatched while holding a qualified word).
package bsg_strap_latch_pkg;

  typedef enum logic [0:0] {
    eSample  = 1'b0,
    eLatched = 1'b1
  } bsg_strap_latch_state_e;

endpackage : bsg_strap_latch_pkg

// File: rtl/bsg_counter_clear_up.sv
// bsg_counter_clear_up
//   Up counter with a synchronous clear and an asynchronous active-high reset.
//   The counter saturates at max_val_p, so it can never wrap even if up_i is
//   held longer than the surrounding logic expects.
// Ports
//   clk_i    in   1        clock
//   reset_i  in   1        asynchronous active-high reset (count -> 0)
//   clear_i  in   1        synchronous clear, wins over up_i
//   up_i     in   1        increment by one (saturating)
//   count_o  out  width_p  current count
module bsg_counter_clear_up #(
  parameter int max_val_p = 1,
  parameter int width_p   = $clog2(max_val_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_val = width_p'(max_val_p);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (up_i && (count_o != max_val)) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule : bsg_counter_clear_up

// File: rtl/bsg_strap_latch.sv
// bsg_strap_latch
//   Samples static strap / tie inputs, waits until they have been identical
//   for stable_cycles_p consecutive comparisons, then holds them as a clean
//   registered config word. If the inputs never settle, a latch is forced
//   after timeout_p cycles of sampling and unstable_o is set. Software can
//   request a fresh sampling pass with relatch_i while a word is held.
// Ports
//   clk_i      in   1        clock
//   reset_i    in   1        asynchronous active-high reset
//   strap_i    in   width_p  raw strap/tie value
//   relatch_i  in   1        request a new sampling pass (only while latched)
//   data_o     out  width_p  latched strap word
//   valid_o    out  1        data_o qualified; sticky until reset
//   busy_o     out  1        sampling pass in progress
//   changed_o  out  1        one-cycle pulse: re-latch produced a new value
//   unstable_o out  1        sticky: some latch was forced by timeout
module bsg_strap_latch
  import bsg_strap_latch_pkg::*;
#(
  parameter int width_p         = 16,
  parameter int stable_cycles_p = 4,
  parameter int timeout_p       = 64
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] strap_i,
  input  logic               relatch_i,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               changed_o,
  output logic               unstable_o
);

  localparam int cnt_w = $clog2(stable_cycles_p + 1);
  localparam int tmr_w = $clog2(timeout_p + 1);

  localparam logic [cnt_w-1:0] stable_last = cnt_w'(stable_cycles_p - 1);
  localparam logic [tmr_w-1:0] timer_last  = tmr_w'(timeout_p - 1);

  bsg_strap_latch_state_e state_reg;
  logic [width_p-1:0]     shadow_reg;
  logic                   shadow_v_reg;
  logic [width_p-1:0]     data_reg;
  logic                   valid_reg;
  logic                   changed_reg;
  logic                   unstable_reg;

  logic [cnt_w-1:0]       stable_cnt;
  logic [tmr_w-1:0]       timer;

  logic                   in_sample;
  logic                   match;
  logic                   normal_latch;
  logic                   forced_latch;
  logic                   do_latch;
  logic [width_p-1:0]     latch_value;
  logic                   stable_clear;
  logic                   stable_up;
  logic                   timer_clear;
  logic                   timer_up;

  always_comb begin
    in_sample    = (state_reg == eSample);
    match        = shadow_v_reg && (strap_i == shadow_reg);
    normal_latch = in_sample && match && (stable_cnt == stable_last);
    // Timeout only fires when the normal path did not already latch.
    forced_latch = in_sample && !normal_latch && (timer == timer_last);
    do_latch     = normal_latch || forced_latch;
    // A forced latch takes whatever is on the pins right now.
    latch_value  = normal_latch ? shadow_reg : strap_i;

    // Any mismatch (or the first sample of a pass) restarts the stability run.
    stable_clear = in_sample && (!match || do_latch);
    stable_up    = in_sample && match && !do_latch;
    timer_clear  = do_latch;
    timer_up     = in_sample && !do_latch;
  end

  bsg_counter_clear_up #(
    .max_val_p(stable_cycles_p),
    .width_p  (cnt_w)
  ) stable_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(stable_clear),
    .up_i   (stable_up),
    .count_o(stable_cnt)
  );

  bsg_counter_clear_up #(
    .max_val_p(timeout_p),
    .width_p  (tmr_w)
  ) timer_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(timer_clear),
    .up_i   (timer_up),
    .count_o(timer)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg    <= eSample;
      shadow_reg   <= '0;
      shadow_v_reg <= 1'b0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      changed_reg  <= 1'b0;
      unstable_reg <= 1'b0;
    end else begin
      changed_reg <= 1'b0;
      case (state_reg)
        eSample: begin
          if (do_latch) begin
            data_reg     <= latch_value;
            valid_reg    <= 1'b1;
            // Only a re-latch can report a change; the first latch has no
            // previous value to compare against.
            changed_reg  <= valid_reg && (latch_value != data_reg);
            if (forced_latch) begin
              unstable_reg <= 1'b1;
            end
            shadow_v_reg <= 1'b0;
            state_reg    <= eLatched;
          end else begin
            // On a match this rewrites the same value, so one path covers
            // the first sample, a mismatch, and a continuing run.
            shadow_reg   <= strap_i;
            shadow_v_reg <= 1'b1;
          end
        end
        eLatched: begin
          if (relatch_i) begin
            state_reg <= eSample;
          end
        end
        default: begin
          state_reg <= eSample;
        end
      endcase
    end
  end

  assign data_o     = data_reg;
  assign valid_o    = valid_reg;
  assign busy_o     = (state_reg == eSample);
  assign changed_o  = changed_reg;
  assign unstable_o = unstable_reg;

endmodule : bsg_strap_latch
